// File: rtl/accumulator_16bit.sv
// Frame accumulator: sums NUM_SAMPLES unsigned 16-bit operands per frame,
// tracks carry-out of any add as a sticky overflow flag, and holds the
// result behind a valid/ready handshake until downstream takes it.
module accumulator_16bit #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_overflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Count value held while the final operand of a frame is being taken.
    localparam logic [7:0] LAST_COUNT = 8'(NUM_SAMPLES - 1);

    state_e      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  count_q, count_d;

    logic        accept;
    logic [15:0] add_sum;
    logic        add_carry;

    // One 16-bit add per operand; bit 16 of the widened sum is the carry-out.
    assign {add_carry, add_sum} = {1'b0, acc_q} + {1'b0, in_data};

    // Handshake and status outputs; partial sums stay hidden until DONE.
    assign in_ready     = (state_q != DONE) && !clear && !rst;
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state_q == DONE) && !rst;
    assign out_sum      = out_valid ? acc_q : 16'h0000;
    assign out_overflow = out_valid ? ovf_q : 1'b0;
    assign busy         = (state_q != IDLE) && !rst;

    // Next-state and datapath update; clear overrides every other action.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = 16'h0000;
            ovf_d   = 1'b0;
            count_d = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = in_data;
                        ovf_d   = 1'b0;
                        count_d = 8'd1;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        ovf_d   = ovf_q | add_carry;
                        count_d = count_q + 8'd1;
                        if (count_q == LAST_COUNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        count_d = 8'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled at the same edge.
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_accumulator_16bit.sv
// Self-checking bench for accumulator_16bit with NUM_SAMPLES = 4: directed
// scenarios followed by randomized frames checked against a frame-level model.
module tb_accumulator_16bit;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_overflow;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    // Operands accepted in the current frame.
    int frame_q[$];

    accumulator_16bit #(.NUM_SAMPLES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer one operand, confirm it is accepted, and record it in the model.
    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check("in_ready_on_send", in_ready, 1);
        tick();
        in_valid = 1'b0;
        frame_q.push_back(int'(d));
    endtask

    // Model: the result is the true sum mod 2^16; any carry-out in the chain
    // of adds happens exactly when the true sum reaches 2^16.
    task automatic expect_result(input int hold_cycles);
        int total = 0;
        logic [15:0] exp_sum;
        logic        exp_ovf;
        foreach (frame_q[i]) total += frame_q[i];
        exp_sum = 16'(total);
        exp_ovf = (total >= 65536);
        frame_q.delete();
        for (int i = 0; i <= hold_cycles; i++) begin
            check("out_valid_done", out_valid, 1);
            check("out_sum", out_sum, exp_sum);
            check("out_overflow", out_overflow, exp_ovf);
            check("in_ready_done", in_ready, 0);
            check("busy_done", busy, 1);
            if (i < hold_cycles) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("out_valid_after_take", out_valid, 0);
        check("busy_after_take", busy, 0);
        check("in_ready_after_take", in_ready, 1);
        check("out_sum_idle", out_sum, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_sum"}, out_sum, 0);
        check({tag, "_out_overflow"}, out_overflow, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        // Power-up reset.
        #1;
        check_all_zero("rst_init");
        idle_cycles(2);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        check("rst_release_busy", busy, 0);

        // Reset mid-ACCUM for two cycles with traffic on every input.
        send(16'h1111);
        send(16'h2222);
        check("accum_busy", busy, 1);
        check("accum_out_sum_hidden", out_sum, 0);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h3333; out_ready = 1'b1; clear = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick();
        check_all_zero("rst_mid2");
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        frame_q.delete();
        #1;
        check("rst_mid_release_in_ready", in_ready, 1);
        check("rst_mid_release_busy", busy, 0);
        check("rst_mid_release_out_valid", out_valid, 0);

        // Back-to-back frame 1,2,3,4 -> 0x000A.
        send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
        expect_result(0);

        // Overflow frame, then a clean frame showing overflow does not carry over.
        send(16'hFFFF); send(16'h0001); send(16'h0000); send(16'h0005);
        expect_result(0);
        send(16'h0001); send(16'h0001); send(16'h0001); send(16'h0001);
        expect_result(0);

        // Backpressure: result held for 5 cycles.
        send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
        expect_result(5);

        // Bubbles of 3 cycles between operands.
        for (int k = 0; k < N; k++) begin
            send(16'h0010);
            if (k < N - 1) begin
                for (int b = 0; b < 3; b++) begin
                    check("bubble_out_valid", out_valid, 0);
                    check("bubble_busy", busy, 1);
                    tick();
                end
            end
        end
        expect_result(0);

        // Clear with a concurrent operand after two accepts.
        send(16'h0100); send(16'h0200);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h0300;
        #1;
        check("clear_in_ready", in_ready, 0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        frame_q.delete();
        #1;
        check("clear_busy", busy, 0);
        check("clear_out_valid", out_valid, 0);
        send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
        expect_result(0);

        // Clear in DONE with out_ready high: result discarded.
        send(16'h0005); send(16'h0005); send(16'h0005); send(16'h0005);
        check("pre_clear_done_valid", out_valid, 1);
        clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        frame_q.delete();
        #1;
        check("clear_done_out_valid", out_valid, 0);
        check("clear_done_busy", busy, 0);

        // Reset in DONE: no result emitted afterwards.
        send(16'h0007); send(16'h0007); send(16'h0007); send(16'h0007);
        rst = 1'b1;
        #1;
        check_all_zero("rst_done");
        tick();
        rst = 1'b0;
        frame_q.delete();
        #1;
        check("rst_done_out_valid", out_valid, 0);
        check("rst_done_in_ready", in_ready, 1);

        // Randomized frames with random bubbles and backpressure.
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < N; k++) begin
                logic [15:0] d;
                d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
                send(d);
                if (k < N - 1) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    for (int b = 0; b < gap; b++) begin
                        check("rand_bubble_out_valid", out_valid, 0);
                        tick();
                    end
                end
            end
            expect_result(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accumulator_16bit.md
ACCUMULATOR_16BIT -- requirements
Module: accumulator_16bit

Interface
REQ-001 Parameter: NUM_SAMPLES, default 4, number of operands summed per frame; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 clear  input  1  synchronous frame abort, active-high.
REQ-005 in_valid  input  1  in_data holds a valid operand.
REQ-006 in_data  input  16  unsigned operand.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 out_valid  output  1  frame result available.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 out_sum  output  16  frame sum modulo 2^16.
REQ-011 out_overflow  output  1  sticky: at least one add in the frame produced carry-out.
REQ-012 busy  output  1  a frame is in progress or a result is pending.

Function
REQ-013 Internal datapath: one 16-bit unsigned add per accepted operand, carry_in = 0; overflow = carry-out of bit 15.
REQ-014 FSM states: IDLE (no frame), ACCUM (1..NUM_SAMPLES-1 operands taken), DONE (result held).
REQ-015 Accept event = in_valid & in_ready, evaluated on rising clk.
REQ-016 in_ready = 1 in IDLE and ACCUM when clear = 0 and rst = 0; 0 in DONE, while clear = 1, and while rst = 1.
REQ-017 IDLE accept: acc <= in_data, ovf <= 0, count <= 1, go to ACCUM (or DONE if NUM_SAMPLES = 1 — excluded by REQ-001).
REQ-018 ACCUM accept: acc <= acc + in_data (low 16 bits), ovf <= ovf | carry-out, count <= count + 1.
REQ-019 ACCUM accept with count = NUM_SAMPLES-1: go to DONE; out_valid = 1 on the next cycle (latency 1 cycle after final operand).
REQ-020 Cycles with in_valid = 0 leave acc, ovf, count, state unchanged (bubbles allowed anywhere in a frame).
REQ-021 DONE: out_valid = 1, out_sum = acc, out_overflow = ovf; all held stable until out_ready = 1.
REQ-022 DONE with out_ready = 1: result consumed that edge; next state IDLE, count <= 0; out_valid = 0 next cycle.
REQ-023 out_valid = 0, out_sum = 0, out_overflow = 0 in IDLE and ACCUM (partial sums not exposed).
REQ-024 busy = 1 in ACCUM and DONE, 0 in IDLE.
REQ-025 clear = 1 in any state: next state IDLE, acc/ovf/count <= 0; any concurrent in_valid is dropped; in DONE the result is discarded even if out_ready = 1 the same cycle.
REQ-026 Minimum frame period NUM_SAMPLES+1 cycles (NUM_SAMPLES accepts + 1 DONE cycle with out_ready = 1).
REQ-027 count is 8 bits; never exceeds NUM_SAMPLES-1 in ACCUM; no wrap.

Reset
REQ-028 rst = 1 at a rising edge: state IDLE, acc = 0, ovf = 0, count = 0, regardless of state or other inputs.
REQ-029 While rst = 1: in_ready = 0, out_valid = 0, out_sum = 0, out_overflow = 0, busy = 0.
REQ-030 rst has priority over clear, in_valid and out_ready; a mid-frame or DONE reset loses the frame with no result emitted.
REQ-031 First cycle after rst deasserts: in_ready = 1, block in IDLE.

Verification (NUM_SAMPLES = 4)
REQ-032 Reset: rst high 2 cycles mid-ACCUM -> all outputs 0, in_ready 0; after release in_ready = 1, busy = 0.
REQ-033 Back-to-back 0x0001,0x0002,0x0003,0x0004, out_ready = 1 -> one cycle after 4th accept out_valid = 1, out_sum = 0x000A, out_overflow = 0; IDLE next cycle.
REQ-034 Overflow: 0xFFFF,0x0001,0x0000,0x0005 -> out_sum = 0x0005, out_overflow = 1 (sticky after 2nd add); next frame 1,1,1,1 -> out_sum = 0x0004, out_overflow = 0.
REQ-035 Backpressure: result 0x000A with out_ready = 0 for 5 cycles -> out_valid, out_sum held, in_ready = 0; out_ready = 1 -> out_valid = 0 next cycle.
REQ-036 Bubbles: operands 0x0010 with in_valid low 3 cycles between each -> out_sum = 0x0040, latency 1 cycle after last accept.
REQ-037 clear with in_valid = 1 after 2 accepts (0x0100,0x0200) -> operand dropped, busy = 0; then 1,2,3,4 -> out_sum = 0x000A.
